uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter BUSY_TO, default 16: number of cycles to wait for tx_busy to rise after tx_start.
REQ-003 SHALL have port clk  input  1: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ: per-requester byte-valid.
REQ-006 SHALL have port req_data  input  8*NUM_REQ: per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_lock  input  NUM_REQ: per-requester request to keep the grant for the next byte.
REQ-008 SHALL have port req_ready  output  NUM_REQ: one-hot accept strobe.
REQ-009 SHALL have port tx_data  output  8: byte presented to the UART transmitter.
REQ-010 SHALL have port tx_start  output  1: one-cycle launch pulse to the transmitter.
REQ-011 SHALL have port tx_busy  input  1: transmitter busy, high from the start bit through the stop bit.
REQ-012 SHALL have port gnt_id  output  $clog2(NUM_REQ): index of the current or last granted requester.
REQ-013 SHALL have port active  output  1: high in every state other than IDLE.
REQ-014 SHALL have port err_to  output  1: one-cycle pulse on busy timeout.

Function
REQ-015 SHALL implement the FSM states IDLE, START, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE with any req_valid high, SHALL select the winner by round-robin, searching from (last_gnt+1) mod NUM_REQ upward.
REQ-017 SHALL assert req_ready[w] combinationally only in IDLE and only for the winner w; the transfer occurs on the cycle where valid and ready are both high.
REQ-018 On a transfer, SHALL register tx_data <= req_data[w], set gnt_id <= w and last_gnt <= w, and move to START.
REQ-019 In START, SHALL assert tx_start for exactly one cycle, then go to WAIT_BUSY with the timeout counter cleared.
REQ-020 In WAIT_BUSY, on tx_busy=1 SHALL go to WAIT_DONE.
REQ-021 In WAIT_BUSY, SHALL increment the timeout counter each cycle; on reaching BUSY_TO-1 with tx_busy=0, SHALL pulse err_to and return to IDLE.
REQ-022 In WAIT_DONE, on tx_busy=0 SHALL return to IDLE.
REQ-023 The next accept SHALL occur no earlier than the cycle after the return to IDLE.
REQ-024 Minimum accept-to-tx_start latency SHALL be 1 cycle.
REQ-025 tx_data SHALL remain stable from the accept until the next accept.
REQ-026 req_valid changes outside IDLE SHALL be ignored; no request is lost, it waits for IDLE.
REQ-027 A single active requester SHALL be granted back-to-back with no starvation check.
REQ-028 With all requesters active, each SHALL be granted once per NUM_REQ accepts.
REQ-029 tx_busy=1 while in IDLE SHALL NOT block arbitration.

Reset
REQ-030 rst=1 SHALL force state to IDLE, req_ready=0, tx_start=0, tx_data=8'h00, gnt_id=0, last_gnt=NUM_REQ-1 (so requester 0 wins first), active=0, err_to=0, timeout counter=0, and lock flag=0.
REQ-031 rst asserted mid-transfer SHALL abort immediately; a tx_start pulse in progress SHALL be dropped on the next edge.

Configuration
REQ-032 With UART_ARB_LOCK_EN defined, req_lock[w]=1 at accept SHALL set lock; while lock is set, IDLE SHALL grant only to owner w (others blocked), and lock SHALL clear at any accept with req_lock[w]=0 or on timeout.
REQ-033 With UART_ARB_LOCK_EN undefined, req_lock SHALL remain a port but be ignored, and pure round-robin SHALL apply.

Structure
REQ-034 A shared package uart_pkg SHALL hold the FSM state typedef (uart_arb_state_t) and the default constants UART_ARB_NUM_REQ and UART_ARB_BUSY_TO.
REQ-035 A single sub-module rr_pick SHALL compute the combinational round-robin winner from req_valid, last_gnt and lock/owner.

Verification
REQ-036 The bench SHALL cover: req0 only, data 8'h55, transmitter model with busy 10 cycles -> one req_ready[0], tx_start the next cycle, tx_data=8'h55, return to IDLE after busy falls.
REQ-037 The bench SHALL cover: all 4 requesters valid continuously -> grants in order 0,1,2,3,0, gnt_id matching.
REQ-038 The bench SHALL cover: req2 valid, transmitter never asserts busy -> err_to pulse exactly 16 cycles after WAIT_BUSY entry, back to IDLE, req1 granted next if valid.
REQ-039 The bench SHALL cover: with UART_ARB_LOCK_EN, req1 locked for 3 bytes with req3 valid -> grants 1,1,1 then 3; without the macro -> grants 1,3,1.
REQ-040 The bench SHALL cover: rst pulsed in WAIT_DONE -> all outputs at reset values the next cycle, first grant to requester 0.
REQ-041 The bench SHALL cover: tx_busy held high in IDLE with req0 valid -> accept still occurs, tx_start issued.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared state type and default sizing for the UART transmit arbiter.
package uart_pkg;

    localparam int unsigned UART_ARB_NUM_REQ = 4;
    localparam int unsigned UART_ARB_BUSY_TO = 16;

    typedef logic [1:0] uart_arb_state_t;

    localparam uart_arb_state_t StIdle     = 2'd0;
    localparam uart_arb_state_t StStart    = 2'd1;
    localparam uart_arb_state_t StWaitBusy = 2'd2;
    localparam uart_arb_state_t StWaitDone = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner select. Searches upward from the slot after
// the last grant; when the lock is held only the owner may win.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   last_gnt_i,
    input  logic               lock_i,
    input  logic [IDX_W-1:0]   owner_i,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    logic [31:0] cand;

    // First valid requester in rotating order, or the owner alone while locked.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand        = '0;
        if (lock_i) begin
            gnt_valid_o = req_valid_i[owner_i];
            gnt_idx_o   = owner_i;
        end else begin
            for (int unsigned off = 1; off <= NUM_REQ; off++) begin
                cand = 32'(last_gnt_i) + off;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!gnt_valid_o && req_valid_i[cand[IDX_W-1:0]]) begin
                    gnt_valid_o = 1'b1;
                    gnt_idx_o   = cand[IDX_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters into one UART
// transmitter, with a timeout on the transmitter's busy handshake.
// Optional feature: define UART_ARB_LOCK_EN to let a requester hold the grant
// across consecutive bytes via req_lock.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = UART_ARB_NUM_REQ,
    parameter int unsigned BUSY_TO = UART_ARB_BUSY_TO
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       active,
    output logic                       err_to
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(BUSY_TO + 1);

    uart_arb_state_t state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [IdxW-1:0] gnt_id_q, gnt_id_d;
    logic [IdxW-1:0] last_gnt_q, last_gnt_d;
    logic            lock_q, lock_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_to_q, err_to_d;

    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;
    logic            accept;

`ifndef UART_ARB_LOCK_EN
    // Lock requests have no effect in this build.
    logic unused_req_lock;
    assign unused_req_lock = ^req_lock;
`endif

    // While locked, the owner is always the last granted requester.
    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IdxW)
    ) u_rr_pick (
        .req_valid_i(req_valid),
        .last_gnt_i (last_gnt_q),
        .lock_i     (lock_q),
        .owner_i    (last_gnt_q),
        .gnt_valid_o(pick_valid),
        .gnt_idx_o  (pick_idx)
    );

    assign accept = (state_q == StIdle) && pick_valid && !rst;

    // One-hot ready strobe to the winner, only while idle.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    // Next-state: accept -> launch pulse -> wait for busy to rise -> wait for busy to fall.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        gnt_id_d   = gnt_id_q;
        last_gnt_d = last_gnt_q;
        lock_d     = lock_q;
        cnt_d      = cnt_q;
        err_to_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tx_data_d  = req_data[{pick_idx, 3'b000} +: 8];
                    gnt_id_d   = pick_idx;
                    last_gnt_d = pick_idx;
`ifdef UART_ARB_LOCK_EN
                    lock_d     = req_lock[pick_idx];
`endif
                    state_d    = StStart;
                end
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q == CntW'(BUSY_TO - 1)) begin
                    err_to_d = 1'b1;
                    lock_d   = 1'b0;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; last_gnt resets to the top slot so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_data_q  <= 8'h00;
            gnt_id_q   <= '0;
            last_gnt_q <= IdxW'(NUM_REQ - 1);
            lock_q     <= 1'b0;
            cnt_q      <= '0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            gnt_id_q   <= gnt_id_d;
            last_gnt_q <= last_gnt_d;
            lock_q     <= lock_d;
            cnt_q      <= cnt_d;
            err_to_q   <= err_to_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = (state_q == StStart);
    assign gnt_id   = gnt_id_q;
    assign active   = (state_q != StIdle);
    assign err_to   = err_to_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed sequences, a grant table, and a randomized
// run against a transaction-level timing/arbitration model.
module tb_uart_tx_arb;

    localparam int NR  = 4;
    localparam int BTO = 16;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_lock;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_busy;
    logic [1:0]      gnt_id;
    logic            active;
    logic            err_to;

    int n_vec = 0;
    int n_err = 0;

    // Transmitter model controls.
    int busy_cnt   = 0;
    int busy_len   = 4;
    bit never_busy = 0;
    bit force_busy = 0;

    typedef struct {
        logic [NR-1:0] valid;
        int            busy;
        int            exp_w;
    } vec_t;
    vec_t tbl [12];

`ifdef UART_ARB_LOCK_EN
    localparam int LkN = 4;
    int lk_exp [LkN] = '{1, 1, 1, 3};
`else
    localparam int LkN = 3;
    int lk_exp [LkN] = '{1, 3, 1};
`endif

    uart_tx_arb #(
        .NUM_REQ(NR),
        .BUSY_TO(BTO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_lock (req_lock),
        .req_ready(req_ready),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .gnt_id   (gnt_id),
        .active   (active),
        .err_to   (err_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Busy rises the cycle after tx_start and lasts busy_len cycles.
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (tx_start && !never_busy) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt != 0);

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Rotating priority: the requester right after `last` is closest.
    function automatic int model_pick(logic [NR-1:0] v, int last, bit lk);
        int best;
        int best_d;
        int d;
        best   = -1;
        best_d = NR;
        if (lk) return v[last] ? last : -1;
        for (int i = 0; i < NR; i++) begin
            d = (i - last - 1 + 2 * NR) % NR;
            if (v[i] && d < best_d) begin
                best   = i;
                best_d = d;
            end
        end
        return best;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_lock = '0; force_busy = 1'b0; never_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_acc(input int limit, output int w);
        w = -1;
        for (int i = 0; i < limit; i++) begin
            if (req_ready != '0) begin
                for (int b = NR - 1; b >= 0; b--) if (req_ready[b]) w = b;
                break;
            end
            step();
        end
        if (w < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_wait: no req_ready within %0d cycles", limit);
        end
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (active !== 1'b0 && n < limit) begin
            step();
            n++;
        end
        if (active !== 1'b0) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_wait: active still high after %0d cycles", limit);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        logic [7:0] exp_byte;
        int next_free, acc_cyc, start_cyc, err_cyc, last_m, exp_gnt;
        bit lock_m;
        logic [7:0] exp_data;
        logic [NR-1:0] exp_rdy;

        tbl[0]  = '{4'b0001, 2, 0};
        tbl[1]  = '{4'b1111, 1, 1};
        tbl[2]  = '{4'b1111, 3, 2};
        tbl[3]  = '{4'b1111, 1, 3};
        tbl[4]  = '{4'b1111, 2, 0};
        tbl[5]  = '{4'b0101, 1, 2};
        tbl[6]  = '{4'b0101, 3, 0};
        tbl[7]  = '{4'b1000, 1, 3};
        tbl[8]  = '{4'b0110, 2, 1};
        tbl[9]  = '{4'b0001, 1, 0};
        tbl[10] = '{4'b0001, 1, 0};
        tbl[11] = '{4'b1100, 2, 2};

        rst = 1'b1; req_valid = '0; req_data = '0; req_lock = '0;
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("ready_during_rst", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0; req_valid = '0;
        #1;
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_gnt_id", 32'(gnt_id), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_err_to", 32'(err_to), 0);
        chk("rst_ready", 32'(req_ready), 0);

        // Single requester, 10-cycle busy.
        req_valid = 4'b0001; req_data = 32'hDEAD_BE55; busy_len = 10;
        #1;
        chk("b10_ready", 32'(req_ready), 1);
        chk("b10_active_acc", 32'(active), 0);
        step();
        req_valid = '0;
        #1;
        chk("b10_start", 32'(tx_start), 1);
        chk("b10_data", 32'(tx_data), 32'h55);
        chk("b10_ready_busy", 32'(req_ready), 0);
        step();
        chk("b10_start_once", 32'(tx_start), 0);
        wait_idle(40, n);
        chk("b10_idle_latency", n, 11);
        chk("b10_data_hold", 32'(tx_data), 32'h55);

        // Grant table, valid dropped between bytes.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step();
            req_valid = tbl[i].valid; req_data = $urandom; busy_len = tbl[i].busy;
            #1;
            wait_acc(40, w);
            chk("tbl_ready", 32'(req_ready), 1 << tbl[i].exp_w);
            exp_byte = req_data[tbl[i].exp_w * 8 +: 8];
            step();
            req_valid = '0;
            #1;
            chk("tbl_start", 32'(tx_start), 1);
            chk("tbl_data", 32'(tx_data), 32'(exp_byte));
            chk("tbl_gnt_id", 32'(gnt_id), tbl[i].exp_w);
            wait_idle(40, n);
        end

        // All requesters held valid.
        do_reset();
        busy_len = 1; req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            wait_acc(20, w);
            chk("rr_all_grant", w, k % 4);
            step();
            chk("rr_all_gnt_id", 32'(gnt_id), k % 4);
        end
        req_valid = '0;
        #1;
        wait_idle(20, n);

        // Busy never rises: timeout then next requester.
        do_reset();
        never_busy = 1'b1; busy_len = 2; req_valid = 4'b0100;
        #1;
        wait_acc(4, w);
        chk("to_grant2", w, 2);
        for (int k = 1; k <= 19; k++) begin
            step();
            if (k == 1) req_valid = 4'b0110;
            if (k == 19) begin
                req_valid  = '0;
                never_busy = 1'b0;
            end
            #1;
            if (k == 17) chk("to_err_early", 32'(err_to), 0);
            if (k == 18) begin
                chk("to_err_pulse", 32'(err_to), 1);
                chk("to_idle", 32'(active), 0);
                chk("to_next_ready", 32'(req_ready), 32'b0010);
            end
            if (k == 19) begin
                chk("to_err_clear", 32'(err_to), 0);
                chk("to_next_start", 32'(tx_start), 1);
                chk("to_next_gnt", 32'(gnt_id), 1);
            end
        end
        wait_idle(40, n);

        // Lock request from requester 1 competing with requester 3.
        do_reset();
        busy_len = 2; req_valid = 4'b1010; req_data = 32'h3C00_A500;
        for (int k = 0; k < LkN; k++) begin
            req_lock = (k < 2) ? 4'b0010 : 4'b0000;
            #1;
            wait_acc(60, w);
            chk("lock_grant", w, lk_exp[k]);
            step();
        end
        req_valid = '0; req_lock = '0;
        #1;
        wait_idle(40, n);

        // Reset while waiting for busy to fall.
        do_reset();
        req_valid = 4'b0001; req_data = 32'h0000_00A7; busy_len = 10;
        #1;
        wait_acc(4, w);
        step();
        req_valid = '0;
        step();
        step();
        step();
        chk("mid_rst_active", 32'(active), 1);
        @(negedge clk);
        rst = 1'b1; req_valid = 4'b0011;
        #1;
        chk("mid_rst_ready_in_rst", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_active_after", 32'(active), 0);
        chk("mid_rst_tx_start", 32'(tx_start), 0);
        chk("mid_rst_tx_data", 32'(tx_data), 0);
        chk("mid_rst_gnt_id", 32'(gnt_id), 0);
        chk("mid_rst_err_to", 32'(err_to), 0);
        chk("mid_rst_first_grant", 32'(req_ready), 1);
        step();
        req_valid = '0;
        #1;
        wait_idle(40, n);

        // Busy held high while idle must not block arbitration.
        do_reset();
        force_busy = 1'b1; busy_len = 2; req_valid = 4'b0001;
        #1;
        chk("busy_idle_ready", 32'(req_ready), 1);
        step();
        req_valid = '0;
        #1;
        chk("busy_idle_start", 32'(tx_start), 1);
        step();
        step();
        force_busy = 1'b0;
        #1;
        wait_idle(40, n);

        // Randomized run against the transaction model.
        do_reset();
        next_free = 0; acc_cyc = -1; start_cyc = -1; err_cyc = -1;
        last_m = NR - 1; exp_gnt = 0; exp_data = 8'h00; lock_m = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            req_valid = NR'($urandom);
            req_lock  = NR'($urandom);
            req_data  = $urandom;
            #1;
            exp_rdy = '0;
            w = -1;
            if (c >= next_free) begin
                w = model_pick(req_valid, last_m, lock_m);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rnd_tx_start", 32'(tx_start), 32'(c == start_cyc));
            chk("rnd_active", 32'(active), 32'(c > acc_cyc && c < next_free));
            chk("rnd_err_to", 32'(err_to), 32'(c == err_cyc));
            chk("rnd_tx_data", 32'(tx_data), 32'(exp_data));
            chk("rnd_gnt_id", 32'(gnt_id), exp_gnt);
            if (w >= 0) begin
                acc_cyc   = c;
                start_cyc = c + 1;
                last_m    = w;
                exp_gnt   = w;
                exp_data  = req_data[w * 8 +: 8];
`ifdef UART_ARB_LOCK_EN
                lock_m    = req_lock[w];
`endif
                if ($urandom_range(0, 7) == 0) begin
                    never_busy = 1'b1;
                    next_free  = c + 2 + BTO;
                    err_cyc    = next_free;
                    lock_m     = 1'b0;
                end else begin
                    never_busy = 1'b0;
                    busy_len   = $urandom_range(1, 6);
                    next_free  = c + 3 + busy_len;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
